// File: rtl/reset_seq_pkg.sv
// Shared types and default parameter values for the reset sequencer.
package reset_seq_pkg;

  localparam int unsigned DEF_NUM_CH    = 4;
  localparam int unsigned DEF_CNT_W     = 8;
  localparam int unsigned DEF_MIN_PULSE = 2;
  localparam int unsigned DEF_POR_LEN   = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/rst_lsb_find.sv
// Lowest-set-bit finder: isolates the lowest set bit of vec as a one-hot.
module rst_lsb_find #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] vec,
  output logic [W-1:0] onehot,
  output logic         valid
);

  // Two's-complement trick keeps only the lowest set bit.
  assign onehot = vec & (~vec + W'(1));
  assign valid  = |vec;

endmodule

// File: rtl/reset_sequencer.sv
// Per-channel reset sequencer: asserts masked channels for a programmable
// length, then releases them one by one (or together) with a stagger gap.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_CH    = DEF_NUM_CH,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned MIN_PULSE = DEF_MIN_PULSE,
  parameter int unsigned POR_LEN   = DEF_POR_LEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [NUM_CH-1:0] req_mask_i,
  input  logic [CNT_W-1:0]  req_len_i,
  input  logic [CNT_W-1:0]  req_stagger_i,
  output logic [NUM_CH-1:0] rst_n_o,
  output logic              busy_o,
  output logic              done_o
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    scnt_q, scnt_d;
  logic [CNT_W-1:0]    stag_q, stag_d;
  logic [NUM_CH-1:0]   pend_q, pend_d;
  logic [NUM_CH-1:0]   rstn_d;
  logic [NUM_CH-1:0]   lsb_oh;
  logic                lsb_valid;
  logic [CNT_W-1:0]    eff_len;

  assign eff_len = (req_len_i < CNT_W'(MIN_PULSE)) ? CNT_W'(MIN_PULSE) : req_len_i;

  rst_lsb_find #(.W(NUM_CH)) u_lsb (
    .vec    (pend_q),
    .onehot (lsb_oh),
    .valid  (lsb_valid)
  );

  // Next-state and datapath updates; pend tracks masked channels still low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    scnt_d  = scnt_q;
    stag_d  = stag_q;
    pend_d  = pend_q;
    rstn_d  = rst_n_o;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          stag_d = req_stagger_i;
          if (req_mask_i == '0) begin
            state_d = DONE;
          end else begin
            state_d = ASSERT;
            cnt_d   = eff_len;
            pend_d  = req_mask_i;
            rstn_d  = rst_n_o & ~req_mask_i;
          end
        end
      end
      ASSERT: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = RELEASE;
          scnt_d  = stag_q;
          if (stag_q == '0) begin
            rstn_d = rst_n_o | pend_q;
            pend_d = '0;
          end else begin
            rstn_d = rst_n_o | lsb_oh;
            pend_d = pend_q & ~lsb_oh;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RELEASE: begin
        if (!lsb_valid) begin
          state_d = DONE;
        end else if (scnt_q <= CNT_W'(1)) begin
          rstn_d = rst_n_o | lsb_oh;
          pend_d = pend_q & ~lsb_oh;
          scnt_d = stag_q;
        end else begin
          scnt_d = scnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset restarts the power-on sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ASSERT;
      cnt_q       <= CNT_W'(POR_LEN);
      scnt_q      <= '0;
      stag_q      <= '0;
      pend_q      <= '1;
      rst_n_o     <= '0;
      req_ready_o <= 1'b0;
      busy_o      <= 1'b1;
      done_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      scnt_q      <= scnt_d;
      stag_q      <= stag_d;
      pend_q      <= pend_d;
      rst_n_o     <= rstn_d;
      req_ready_o <= (state_d == IDLE);
      busy_o      <= (state_d != IDLE);
      done_o      <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus random traffic, checked
// against a release-schedule model (per-channel release cycle, done cycle).
module tb_reset_sequencer;

  localparam int unsigned NCH  = 4;
  localparam int unsigned CW   = 8;
  localparam int unsigned MINP = 2;
  localparam int unsigned PORL = 5;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [NCH-1:0] req_mask;
  logic [CW-1:0]  req_len;
  logic [CW-1:0]  req_stagger;
  logic [NCH-1:0] rst_n;
  logic          busy;
  logic          done;

  reset_sequencer #(
    .NUM_CH(NCH), .CNT_W(CW), .MIN_PULSE(MINP), .POR_LEN(PORL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_mask_i    (req_mask),
    .req_len_i     (req_len),
    .req_stagger_i (req_stagger),
    .rst_n_o       (rst_n),
    .busy_o        (busy),
    .done_o        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: cycle t is the cycle following rising edge t.
  int           t = 0;
  bit           armed = 0;
  logic [NCH-1:0] seq_mask = '0;
  logic [NCH-1:0] base_val = '0;
  int           rel_at [NCH];
  int           done_at = 0;

  function automatic logic [NCH-1:0] model_rstn(int tt);
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++)
      r[c] = seq_mask[c] ? (tt >= rel_at[c]) : base_val[c];
    return r;
  endfunction

  task automatic schedule(int k, logic [NCH-1:0] m, int eff, int s, logic [NCH-1:0] base);
    int j;
    int last;
    j = 0;
    last = k;
    base_val = base;
    seq_mask = m;
    for (int c = 0; c < NCH; c++) begin
      rel_at[c] = 0;
      if (m[c]) begin
        rel_at[c] = k + 1 + eff + j * s;
        last = rel_at[c];
        j++;
      end
    end
    done_at = last + 1;
  endtask

  task automatic model_edge();
    int eff;
    if (reset) begin
      schedule(t, '1, int'(PORL), 0, '0);
      armed = 1;
    end else if (armed && req_valid && (t > done_at)) begin
      eff = (int'(req_len) < int'(MINP)) ? int'(MINP) : int'(req_len);
      schedule(t, req_mask, eff, int'(req_stagger), model_rstn(t));
    end
    t++;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (armed) begin
      chk("rst_n",  32'(rst_n), 32'(model_rstn(t)));
      chk("ready",  32'(req_ready), 32'(t > done_at));
      chk("busy",   32'(busy), 32'(!(t > done_at)));
      chk("done",   32'(done), 32'(t == done_at));
    end
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic request(logic [NCH-1:0] m, int len, int s);
    req_valid   = 1'b1;
    req_mask    = m;
    req_len     = CW'(len);
    req_stagger = CW'(s);
    step();
    req_valid   = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_mask = '0;
    req_len = '0;
    req_stagger = '0;

    // Power-on: three reset cycles then the POR sequence.
    steps(3);
    reset = 1'b0;
    steps(10);

    // Staggered release of ch0 then ch2.
    request(4'b0101, 3, 2);
    steps(12);

    // Length below minimum, simultaneous release.
    request(4'b1111, 0, 0);
    steps(8);

    // Empty mask completes immediately.
    request(4'b0000, 9, 0);
    steps(4);

    // Reset during RELEASE after ch1 is already high.
    request(4'b1110, 2, 3);
    steps(4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    steps(10);

    // Maximum length does not wrap.
    request(4'b0001, 255, 0);
    steps(260);

    // Valid held through busy with a changing mask.
    req_valid = 1'b1;
    req_len = CW'(2);
    req_stagger = CW'(1);
    for (int i = 0; i < 30; i++) begin
      req_mask = NCH'($urandom);
      step();
    end
    req_valid = 1'b0;
    steps(12);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      req_valid   = ($urandom_range(1, 0) == 1);
      req_mask    = NCH'($urandom);
      req_len     = CW'($urandom_range(6, 0));
      req_stagger = CW'($urandom_range(3, 0));
      reset       = ($urandom_range(59, 0) == 0);
      step();
    end
    reset = 1'b0;
    req_valid = 1'b0;
    steps(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of independent reset channels (range 1..32).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the length and stagger fields.
REQ-003 The block SHALL have parameter MIN_PULSE, default 2, meaning the minimum assert length in cycles.
REQ-004 The block SHALL have parameter POR_LEN, default 16, meaning the power-on assert length in cycles.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high global reset.
REQ-007 The block SHALL have port req_valid_i, input, 1 bit: sequence request valid.
REQ-008 The block SHALL have port req_ready_o, output, 1 bit: block can accept a request.
REQ-009 The block SHALL have port req_mask_i, input, NUM_CH bits: channels affected by the request.
REQ-010 The block SHALL have port req_len_i, input, CNT_W bits: assert length in cycles.
REQ-011 The block SHALL have port req_stagger_i, input, CNT_W bits: cycles between successive channel releases.
REQ-012 The block SHALL have port rst_n_o, output, NUM_CH bits: active-low per-channel resets.
REQ-013 The block SHALL have port busy_o, output, 1 bit: high in any state other than IDLE.
REQ-014 The block SHALL have port done_o, output, 1 bit: one-cycle pulse when a sequence completes.

Function
REQ-015 The FSM SHALL have the states IDLE, ASSERT, RELEASE and DONE; req_ready_o SHALL equal (state==IDLE).
REQ-016 The block SHALL accept a request on a rising edge where req_valid_i && req_ready_o, latching the mask, len and stagger.
REQ-017 On accept, the block SHALL use an effective length of max(req_len_i, MIN_PULSE).
REQ-018 After an accept at edge k, the masked channels SHALL be low from cycle k+1 for exactly the effective length of cycles (the ASSERT state).
REQ-019 Unmasked channels SHALL hold their current value throughout a sequence.
REQ-020 On entry to RELEASE, the lowest-index pending masked channel SHALL go high in that same cycle.
REQ-021 With stagger=0, all masked channels SHALL go high together on RELEASE entry.
REQ-022 With stagger=s>0, each next pending channel SHALL release s cycles after the previous one, in ascending index order.
REQ-023 The cycle after the last release, the FSM SHALL be in DONE with done_o=1 for exactly one cycle, then return to IDLE.
REQ-024 A request with mask==0 SHALL be accepted, SHALL skip ASSERT and RELEASE, and SHALL pulse done_o in cycle k+1.
REQ-025 req_valid_i while busy SHALL be ignored: no queuing, and inputs are not sampled.
REQ-026 The assert and stagger counters SHALL be CNT_W bits wide and SHALL NOT wrap; a length of 2^CNT_W-1 SHALL give exactly that many cycles.

Reset
REQ-027 While reset=1, the block SHALL drive rst_n_o='0, req_ready_o=0, busy_o=1 and done_o=0.
REQ-028 While reset=1, the FSM SHALL be in ASSERT with mask all-ones, effective length POR_LEN and stagger 0.
REQ-029 The POR_LEN count SHALL start on the first cycle with reset=0; the POR sequence SHALL end with a DONE pulse.
REQ-030 Reset asserted mid-sequence SHALL override everything: all channels SHALL go low at the next edge and the POR sequence SHALL restart.

Structure
REQ-031 Package reset_seq_pkg SHALL hold the state enum type and the default values of NUM_CH, CNT_W, MIN_PULSE and POR_LEN.
REQ-032 There SHALL be one sub-module, rst_lsb_find, a parametrised lowest-set-bit finder (one-hot plus valid) over the pending-release vector.

Verification
REQ-033 The bench SHALL cover: NUM_CH=4, POR_LEN=5, reset high 3 cycles then low -> rst_n_o=0000 for 5 cycles, then 1111, done_o the next cycle, ready the cycle after.
REQ-034 The bench SHALL cover: mask=0101, len=3, stagger=2 -> ch0 and ch2 low 3 cycles, ch0 high, ch2 high 2 cycles later, done_o the next cycle, ch1 and ch3 constant 1.
REQ-035 The bench SHALL cover: mask=1111, len=0, MIN_PULSE=2, stagger=0 -> all channels low exactly 2 cycles, released together.
REQ-036 The bench SHALL cover: mask=0000, len=9 -> rst_n_o unchanged, done_o at k+1, ready at k+2.
REQ-037 The bench SHALL cover: reset pulsed during RELEASE of mask=1110 (ch1 already high) -> rst_n_o=0000 at the next edge, full POR_LEN sequence repeats.
REQ-038 The bench SHALL cover: req_valid_i held high with changing mask during busy -> exactly one accept, a second accept only in the cycle after DONE.
